// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Serial byte loader that fills a small instruction memory in
//                bursts and serves combinational instruction fetches.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            len,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [DATA_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            words_loaded
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam int         c_BPW     = DATA_WIDTH / 8;
    localparam int         c_BW      = $clog2(c_BPW);
    localparam logic [4:0] c_MAX_LEN = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    // Only the lower bytes are staged; the final byte goes straight to memory.
    logic [DATA_WIDTH-9:0] r_partial;
    logic [c_BW-1:0]       r_byte_idx;
    logic [c_AW-1:0]       r_word_idx;
    logic [4:0]            r_len;
    logic [4:0]            r_words;

    logic                  w_accept;
    logic                  w_word_full;
    logic                  w_last_word;
    logic [4:0]            w_eff_len;
    logic                  w_unused_fetch;

    assign w_eff_len   = (len == 5'd0 || len > c_MAX_LEN) ? c_MAX_LEN : len;
    assign w_accept    = byte_valid && (r_state == S_LOAD);
    assign w_word_full = w_accept && (r_byte_idx == c_BW'(c_BPW - 1));
    assign w_last_word = w_word_full && ((r_words + 5'd1) == r_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_last_word) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_partial  <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_words    <= '0;
            r_len      <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_len      <= w_eff_len;
            r_partial  <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_words    <= '0;
        end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + c_BW'(1);
            if (w_word_full) begin
                r_mem[r_word_idx] <= {byte_in, r_partial};
                r_word_idx        <= r_word_idx + c_AW'(1);
                r_words           <= r_words + 5'd1;
            end else begin
                r_partial[{r_byte_idx, 3'b000} +: 8] <= byte_in;
            end
        end
    end

    // Asynchronous read: a same-cycle write is visible only after the edge.
    assign instr_out    = r_mem[fetch_addr[c_AW+1:2]];
    assign words_loaded = r_words;

    assign w_unused_fetch = ^{fetch_addr[DATA_WIDTH-1:c_AW+2], fetch_addr[1:0]};

endmodule

`default_nettype wire
